cci_test_ctrl: RTL

// - CSR-driven run controller downstream of the generic CSR manager; consumes test CSR write strobes, returns read values.
// - Holds run config (base, length, cycle limit), sequences engine start/run/drain/done, counts cycles/requests/responses.
// - Sits between the CSR manager and the per-test traffic engine; engine issues reqs while eng_active, reports via strobes.

---
 rtl/cci_test_ctrl_pkg.sv | 29 ++
 rtl/cci_test_ctrl_outstanding.sv | 32 +++
 rtl/cci_test_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/cci_test_ctrl_pkg.sv
// Shared types and CSR slot indices for the test run controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cci_test_ctrl_pkg;

    // Run state, encoded exactly as it is reported in status bits [1:0]
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } t_test_ctrl_state;

    // Test CSR slot indices as seen by software
    localparam int CSR_CMD    = 0;
    localparam int CSR_BASE   = 1;
    localparam int CSR_LINES  = 2;
    localparam int CSR_LIMIT  = 3;
    localparam int CSR_CYCLES = 4;
    localparam int CSR_REQS   = 5;
    localparam int CSR_RSPS   = 6;

    // Default width of the cycle/request/response counters
    localparam int TEST_CTR_BITS = 48;

    // Counter value as presented on a 64-bit CSR read (zero-extended)
    typedef logic [63:0] t_test_ctr;

endpackage

// File: rtl/cci_test_ctrl_outstanding.sv
// Up/down count of requests issued but not yet answered.
// Latency: count updates on the clock edge after inc/dec/clr.
// Backpressure: none; full is advisory, the count may exceed MAX_OUTSTANDING.
module cci_test_ctrl_outstanding #(
    parameter int  MAX_OUTSTANDING = 512,
    localparam int CNT_BITS        = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                inc,
    input  logic                dec,
    output logic [CNT_BITS-1:0] count,
    output logic                zero,
    output logic                full
);

    // Clear wins over traffic; a simultaneous inc and dec leaves the count unchanged
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && !dec) begin
            count <= count + CNT_BITS'(1);
        end else if (dec && !inc) begin
            count <= count - CNT_BITS'(1);
        end
    end

    assign zero = (count == '0);
    assign full = (count == CNT_BITS'(MAX_OUTSTANDING));

endmodule

// File: rtl/cci_test_ctrl.sv
// CSR-driven run controller: holds test config, sequences IDLE/RUN/DRAIN/DONE, counts traffic.
// Latency: eng_start/eng_active follow a start write by one cycle; csr_rd_data lags state by one cycle.
// Backpressure: none; the engine may issue only while eng_active, violations set the sticky err bit.
module cci_test_ctrl
    import cci_test_ctrl_pkg::*;
#(
    parameter int NUM_TEST_CSRS   = 8,
    parameter int CTR_BITS        = TEST_CTR_BITS,
    parameter int MAX_OUTSTANDING = 512
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_TEST_CSRS-1:0]    csr_wr_en,
    input  logic [63:0]                 csr_wr_data,
    output logic [NUM_TEST_CSRS*64-1:0] csr_rd_data,
    output logic [63:0]                 eng_base,
    output logic [31:0]                 eng_num_lines,
    output logic                        eng_start,
    output logic                        eng_active,
    input  logic                        eng_req,
    input  logic                        eng_rsp
);

    localparam int OUT_BITS = $clog2(MAX_OUTSTANDING) + 1;

    t_test_ctrl_state      state;
    t_test_ctrl_state      state_nxt;
    logic [63:0]           cfg_base;
    logic [31:0]           cfg_num_lines;
    logic [31:0]           cfg_cycle_limit;
    logic [CTR_BITS-1:0]   cycles;
    logic [CTR_BITS-1:0]   reqs;
    logic [CTR_BITS-1:0]   rsps;
    logic                  err;

    logic [OUT_BITS-1:0]   out_count;
    logic                  out_zero;
    logic                  out_full;

    logic                  in_run;
    logic                  in_drain;
    logic                  idle_or_done;
    logic                  cmd_start;
    logic                  cmd_stop;
    logic                  start_go;
    logic                  req_cnt;
    logic                  rsp_cnt;
    logic                  err_evt;
    logic                  hit_lines;
    logic                  hit_limit;

    logic [NUM_TEST_CSRS*64-1:0] rd_nxt;

    assign in_run       = (state == ST_RUN);
    assign in_drain     = (state == ST_DRAIN);
    assign idle_or_done = (state == ST_IDLE) || (state == ST_DONE);

    // Start beats stop when both bits arrive in the same write; stop only matters in RUN
    assign cmd_start = csr_wr_en[CSR_CMD] && csr_wr_data[0];
    assign cmd_stop  = csr_wr_en[CSR_CMD] && csr_wr_data[1];
    assign start_go  = cmd_start && idle_or_done;

    // Only traffic inside the legal window is counted; everything else is an error
    assign req_cnt = eng_req && in_run;
    assign rsp_cnt = eng_rsp && (in_run || in_drain) && !out_zero;
    assign err_evt = (eng_req && !in_run) || (eng_rsp && !rsp_cnt) || (req_cnt && out_full);

    // Request target includes this cycle's request so RUN ends right after the last one
    assign hit_lines = ((reqs + CTR_BITS'(eng_req)) == CTR_BITS'(cfg_num_lines));
    assign hit_limit = (cfg_cycle_limit != '0) &&
                       ((cycles + CTR_BITS'(1)) == CTR_BITS'(cfg_cycle_limit));

    assign eng_base      = cfg_base;
    assign eng_num_lines = cfg_num_lines;
    assign eng_active    = in_run;

    cci_test_ctrl_outstanding #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_outstanding (
        .clk   (clk),
        .reset (reset),
        .clr   (start_go),
        .inc   (req_cnt),
        .dec   (rsp_cnt),
        .count (out_count),
        .zero  (out_zero),
        .full  (out_full)
    );

    // Next-state selection for the run sequencer
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (cmd_start) state_nxt = ST_RUN;
            ST_RUN:           if (hit_lines || cmd_stop || hit_limit) state_nxt = ST_DRAIN;
            ST_DRAIN:         if (out_zero && !eng_rsp) state_nxt = ST_DONE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    // State register and the one-cycle start pulse that coincides with entry to RUN
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            eng_start <= 1'b0;
        end else begin
            state     <= state_nxt;
            eng_start <= start_go;
        end
    end

    // Config registers are frozen while a run is in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_base        <= '0;
            cfg_num_lines   <= '0;
            cfg_cycle_limit <= '0;
        end else if (idle_or_done) begin
            if (csr_wr_en[CSR_BASE])  cfg_base        <= csr_wr_data;
            if (csr_wr_en[CSR_LINES]) cfg_num_lines   <= csr_wr_data[31:0];
            if (csr_wr_en[CSR_LIMIT]) cfg_cycle_limit <= csr_wr_data[31:0];
        end
    end

    // Run statistics, cleared on every accepted start, free-running wrap otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            cycles <= '0;
            reqs   <= '0;
            rsps   <= '0;
        end else if (start_go) begin
            cycles <= '0;
            reqs   <= '0;
            rsps   <= '0;
        end else begin
            if (in_run || in_drain) cycles <= cycles + CTR_BITS'(1);
            if (req_cnt)            reqs   <= reqs + CTR_BITS'(1);
            if (rsp_cnt)            rsps   <= rsps + CTR_BITS'(1);
        end
    end

    // Sticky protocol error: cleared by start, but a violation in the same cycle still lands
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (err_evt) begin
            err <= 1'b1;
        end else if (start_go) begin
            err <= 1'b0;
        end
    end

    // Read value per slot; unused slots read as zero
    always_comb begin
        rd_nxt = '0;
        rd_nxt[64*CSR_CMD    +: 64] = 64'({err, (state == ST_DONE), state});
        rd_nxt[64*CSR_BASE   +: 64] = cfg_base;
        rd_nxt[64*CSR_LINES  +: 64] = 64'(cfg_num_lines);
        rd_nxt[64*CSR_LIMIT  +: 64] = 64'(cfg_cycle_limit);
        rd_nxt[64*CSR_CYCLES +: 64] = t_test_ctr'(64'(cycles));
        rd_nxt[64*CSR_REQS   +: 64] = t_test_ctr'(64'(reqs));
        rd_nxt[64*CSR_RSPS   +: 64] = t_test_ctr'(64'(rsps));
    end

    // Registered read bus, refreshed every cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            csr_rd_data <= '0;
        end else begin
            csr_rd_data <= rd_nxt;
        end
    end

    // Strobes for read-only slots and the raw count are intentionally not consumed
    logic unused_ok;
    assign unused_ok = ^{csr_wr_en[NUM_TEST_CSRS-1:CSR_CYCLES], out_count};

endmodule
